// File: rtl/recovery_rf_shadow.sv
// recovery_rf_shadow: keeps an ECC-protected copy of every architectural
// register by snooping the core's register-file write ports. On start_i it
// replays the copies into the core's write ports, NumWritePorts registers per
// beat, under a valid/ready handshake. SECDED errors are corrected on the way
// out and counted or flagged.
module recovery_rf_shadow #(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned NumRegs       = 32,
  parameter int unsigned NumWritePorts = 2,
  parameter bit          EccEnable     = 1'b1,
  parameter bit          ZeroReg       = 1'b1,
  parameter int unsigned CntWidth      = 8,
  localparam int unsigned AddrWidth    = $clog2(NumRegs)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               backup_en_i,
  input  logic [NumWritePorts-1:0]           bkp_we_i,
  input  logic [NumWritePorts*AddrWidth-1:0] bkp_waddr_i,
  input  logic [NumWritePorts*DataWidth-1:0] bkp_wdata_i,
  input  logic                               start_i,
  output logic                               restore_valid_o,
  input  logic                               restore_ready_i,
  output logic [NumWritePorts-1:0]           restore_we_o,
  output logic [NumWritePorts*AddrWidth-1:0] restore_waddr_o,
  output logic [NumWritePorts*DataWidth-1:0] restore_wdata_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic [CntWidth-1:0]                ce_cnt_o,
  output logic                               ue_o
);

  // Smallest number of Hamming check bits covering the data plus themselves.
  function automatic int unsigned calc_par_bits(input int unsigned dw);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < dw + r + 1) r++;
    return r;
  endfunction

  localparam int unsigned ParBits   = calc_par_bits(DataWidth);
  // Extended Hamming layout: bit 0 is overall parity, check bits sit at the
  // power-of-two positions, data fills the remaining positions in order.
  localparam int unsigned HamWidth  = DataWidth + ParBits + 1;
  localparam int unsigned CodeWidth = EccEnable ? HamWidth : DataWidth;
  localparam int unsigned NumBeats  = (NumRegs + NumWritePorts - 1) / NumWritePorts;
  localparam int unsigned PtrWidth  = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam int unsigned CntMax    = (32'd1 << CntWidth) - 1;

  localparam logic [0:0] StIdle    = 1'b0;
  localparam logic [0:0] StRestore = 1'b1;

  function automatic logic [HamWidth-1:0] ham_enc(input logic [DataWidth-1:0] data);
    logic [HamWidth-1:0] code;
    int unsigned di;
    code = '0;
    di   = 0;
    for (int unsigned pos = 1; pos < HamWidth; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        code[pos] = data[di];
        di++;
      end
    end
    for (int unsigned j = 0; j < ParBits; j++) begin
      for (int unsigned pos = 1; pos < HamWidth; pos++) begin
        if (((pos & (32'd1 << j)) != 0) && ((pos & (pos - 1)) != 0)) begin
          code[32'd1 << j] ^= code[pos];
        end
      end
    end
    code[0] = ^code[HamWidth-1:1];
    return code;
  endfunction

  // A nonzero syndrome with even overall parity is a double error: the raw
  // data bits are returned untouched so the restore can still complete.
  function automatic void ham_dec(input  logic [HamWidth-1:0]  code_in,
                                  output logic [DataWidth-1:0] data,
                                  output logic                 ce,
                                  output logic                 ue);
    logic [HamWidth-1:0] code;
    int unsigned syn;
    int unsigned di;
    code = code_in;
    syn  = 0;
    ce   = 1'b0;
    ue   = 1'b0;
    for (int unsigned pos = 1; pos < HamWidth; pos++) begin
      if (code[pos]) syn ^= pos;
    end
    if (^code) begin
      if (syn >= HamWidth) begin
        ue = 1'b1;
      end else begin
        ce = 1'b1;
        if (syn != 0) code[syn] = ~code[syn];
      end
    end else if (syn != 0) begin
      ue = 1'b1;
    end
    data = '0;
    di   = 0;
    for (int unsigned pos = 1; pos < HamWidth; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        data[di] = code[pos];
        di++;
      end
    end
  endfunction

  function automatic logic [CodeWidth-1:0] store_enc(input logic [DataWidth-1:0] data);
    logic [HamWidth-1:0] ham;
    logic [HamWidth-1:0] raw;
    ham = ham_enc(data);
    raw = HamWidth'(data);
    return EccEnable ? ham[CodeWidth-1:0] : raw[CodeWidth-1:0];
  endfunction

  function automatic void store_dec(input  logic [CodeWidth-1:0] code,
                                    output logic [DataWidth-1:0] data,
                                    output logic                 ce,
                                    output logic                 ue);
    logic [HamWidth-1:0] ext;
    ext = HamWidth'(code);
    if (EccEnable) begin
      ham_dec(ext, data, ce, ue);
    end else begin
      data = ext[DataWidth-1:0];
      ce   = 1'b0;
      ue   = 1'b0;
    end
  endfunction

  logic [CodeWidth-1:0]     shadow [NumRegs];
  logic [0:0]               state;
  logic [PtrWidth-1:0]      ptr;
  logic [NumWritePorts-1:0] beat_ce;
  logic [NumWritePorts-1:0] beat_ue;
  logic [DataWidth-1:0]     dec_data;
  logic                     dec_ce;
  logic                     dec_ue;
  int unsigned              addr_full;
  int unsigned              ce_total;
  logic [CntWidth-1:0]      ce_next;

  assign restore_valid_o = (state == StRestore);
  assign busy_o          = (state == StRestore);

  // Present the current beat straight from the shadow array so consecutive beats need no wait cycles.
  always_comb begin
    restore_we_o    = '0;
    restore_waddr_o = '0;
    restore_wdata_o = '0;
    beat_ce         = '0;
    beat_ue         = '0;
    dec_data        = '0;
    dec_ce          = 1'b0;
    dec_ue          = 1'b0;
    addr_full       = 0;
    if (state == StRestore) begin
      for (int p = 0; p < NumWritePorts; p++) begin
        addr_full = 32'(ptr) * NumWritePorts + 32'(p);
        restore_waddr_o[p*AddrWidth +: AddrWidth] = AddrWidth'(addr_full);
        if (addr_full < NumRegs) begin
          restore_we_o[p] = 1'b1;
          if (!(ZeroReg && addr_full == 0)) begin
            store_dec(shadow[AddrWidth'(addr_full)], dec_data, dec_ce, dec_ue);
            restore_wdata_o[p*DataWidth +: DataWidth] = dec_data;
            beat_ce[p] = dec_ce;
            beat_ue[p] = dec_ue;
          end
        end
      end
    end
  end

  // Add this beat's corrected errors to the counter, clamping at all-ones.
  always_comb begin
    ce_total = 32'(ce_cnt_o);
    for (int p = 0; p < NumWritePorts; p++) begin
      ce_total = ce_total + 32'(beat_ce[p]);
    end
    ce_next = (ce_total > CntMax) ? CntWidth'(CntMax) : CntWidth'(ce_total);
  end

  // FSM, snooped backup writes (later ports override earlier ones) and error bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= StIdle;
      ptr      <= '0;
      done_o   <= 1'b0;
      ce_cnt_o <= '0;
      ue_o     <= 1'b0;
      for (int i = 0; i < NumRegs; i++) begin
        shadow[i] <= store_enc('0);
      end
    end else begin
      done_o <= 1'b0;
      case (state)
        StIdle: begin
          if (backup_en_i) begin
            for (int p = 0; p < NumWritePorts; p++) begin
              if (bkp_we_i[p]
                  && ({1'b0, bkp_waddr_i[p*AddrWidth +: AddrWidth]} < (AddrWidth+1)'(NumRegs))
                  && !(ZeroReg && bkp_waddr_i[p*AddrWidth +: AddrWidth] == '0)) begin
                shadow[bkp_waddr_i[p*AddrWidth +: AddrWidth]] <=
                  store_enc(bkp_wdata_i[p*DataWidth +: DataWidth]);
              end
            end
          end
          if (start_i) begin
            state <= StRestore;
            ptr   <= '0;
            ue_o  <= 1'b0;
          end
        end
        StRestore: begin
          if (restore_ready_i) begin
            ce_cnt_o <= ce_next;
            if (|beat_ue) ue_o <= 1'b1;
            if (ptr == PtrWidth'(NumBeats - 1)) begin
              state  <= StIdle;
              done_o <= 1'b1;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
